// File: rtl/fpnew_result_reorder_buffer.sv
// In-order retirement buffer for out-of-order FPU opgroup results.
// Slots are reserved at issue, filled by tag, and drained strictly in allocation order.
//
// state        | meaning
// SLOT_FREE    | not allocated
// SLOT_PENDING | allocated, waiting for its result
// SLOT_DONE    | result stored, waiting to retire
module fpnew_result_reorder_buffer #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned IdWidth = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    output logic [IdWidth-1:0] alloc_id_o,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  logic [IdWidth-1:0] res_id_i,
    input  logic [Width-1:0]   res_result_i,
    input  logic [4:0]         res_status_i,
    input  logic               res_ext_bit_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [IdWidth-1:0] out_id_o,
    output logic [Width-1:0]   out_result_o,
    output logic [4:0]         out_status_o,
    output logic               out_ext_bit_o,
    output logic               busy_o,
    output logic               error_o
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_e;

    localparam logic [IdWidth:0] DepthCnt = (IdWidth + 1)'(Depth);

    slot_state_e        state_q  [Depth];
    slot_state_e        state_d  [Depth];
    logic [Width-1:0]   result_q [Depth];
    logic [Width-1:0]   result_d [Depth];
    logic [4:0]         status_q [Depth];
    logic [4:0]         status_d [Depth];
    logic               ext_q    [Depth];
    logic               ext_d    [Depth];
    logic [IdWidth-1:0] head_q, head_d;
    logic [IdWidth-1:0] tail_q, tail_d;
    logic [IdWidth:0]   count_q, count_d;
    logic               error_q, error_d;

    logic alloc_hs;
    logic retire_hs;

    assign alloc_ready_o = (count_q != DepthCnt);
    assign alloc_id_o    = tail_q;
    assign res_ready_o   = 1'b1;
    assign out_valid_o   = (state_q[head_q] == SLOT_DONE);
    assign out_id_o      = head_q;
    assign out_result_o  = out_valid_o ? result_q[head_q] : '0;
    assign out_status_o  = out_valid_o ? status_q[head_q] : '0;
    assign out_ext_bit_o = out_valid_o & ext_q[head_q];
    assign busy_o        = (count_q != '0);
    assign error_o       = error_q;

    assign alloc_hs  = alloc_valid_i & alloc_ready_o;
    assign retire_hs = out_valid_o & out_ready_i;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        status_d = status_q;
        ext_d    = ext_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        error_d  = 1'b0;
        if (flush_i) begin
            for (int i = 0; i < Depth; i++) begin
                state_d[i] = SLOT_FREE;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Writes are judged on the current state, so a write to the slot
            // being allocated this cycle is still illegal.
            if (res_valid_i) begin
                if (state_q[res_id_i] == SLOT_PENDING) begin
                    state_d[res_id_i]  = SLOT_DONE;
                    result_d[res_id_i] = res_result_i;
                    status_d[res_id_i] = res_status_i;
                    ext_d[res_id_i]    = res_ext_bit_i;
                end else begin
                    error_d = 1'b1;
                end
            end
            if (retire_hs) begin
                state_d[head_q] = SLOT_FREE;
                head_d          = head_q + 1'b1;
            end
            if (alloc_hs) begin
                state_d[tail_q] = SLOT_PENDING;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + {{IdWidth{1'b0}}, alloc_hs} - {{IdWidth{1'b0}}, retire_hs};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                state_q[i]  <= SLOT_FREE;
                result_q[i] <= '0;
                status_q[i] <= '0;
                ext_q[i]    <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                state_q[i]  <= state_d[i];
                result_q[i] <= result_d[i];
                status_q[i] <= status_d[i];
                ext_q[i]    <= ext_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

endmodule
